prog_ctrl: RTL and testbench
============================

Name: prog_ctrl

Overview:
- Upstream control stage of the DCM in the GALS producer/consumer design.
- Debounces two push-buttons (up/down) and maintains a 3-bit clock-speed selection.
- When the selection changes, issues a one-cycle update with the new code to the DCM, then confirms the DCM echoed it back on its programming-readback bus.
- Drives a busy indicator and a sticky error flag.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button level must differ from the debounced level before it is accepted. TB-scale value; board value is 1_000_000.
- ACK_TIMEOUT, 8, cycles to wait in WAIT_ACK for the DCM readback to match before flagging an error.
- PROG_W, 3, width of the speed-selection code.

Ports:
- clock  in  1  system clock (DCM reference clock domain)
- reset  in  1  asynchronous, active-high
- btn_up  in  1  raw asynchronous button, increment speed code
- btn_down  in  1  raw asynchronous button, decrement speed code
- prog_ack  in  PROG_W  DCM programming readback (DCM prog_out)
- prog_sel  out  PROG_W  code driven to the DCM prog_in; also the current requested code
- update  out  1  one-cycle pulse to the DCM update input
- busy  out  1  high whenever the FSM is not in IDLE
- error  out  1  sticky; set on ack timeout, cleared only by reset

Behaviour:
- Interface (already decided): reset is `reset`, asynchronous, active-high; clock is `clock`.
- Reset values: prog_sel=0, update=0, busy=0, error=0, FSM=IDLE, all debounce state 0. The DCM also resets to code 0, so both ends agree.
- Input conditioning, per button:
  - 2-FF synchronizer produces level s.
  - Debounce counter increments while s != debounced level d; it clears whenever s == d.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s still != d, d <= s on the next edge.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes d.
- Edge detect: a registered rising-edge pulse on d, one cycle wide, per button.
- FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE:
  - up pulse only and prog_sel<7: prog_sel <= prog_sel+1, go to ISSUE.
  - down pulse only and prog_sel>0: prog_sel <= prog_sel-1, go to ISSUE.
  - Saturated request (up at 7, down at 0): ignored, stay in IDLE, no update.
  - Up and down pulses in the same cycle: both ignored.
- ISSUE: update=1 for exactly this cycle; prog_sel is stable and already holds the new code. Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - prog_ack == prog_sel: go to IDLE. The DCM registers prog_out on the update cycle, so a compliant DCM matches on the first WAIT_ACK cycle.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT-1 without a match, set error=1 and go to IDLE. prog_sel keeps the requested value; no automatic retry.
- Pulses arriving while busy: dropped, not queued.
- Latency: btn_up rising (first sampling edge) to update high is DEBOUNCE_CYCLES+4 cycles. This covers 2 sync, DEBOUNCE_CYCLES debounce, 1 edge register and 1 IDLE decision. Benches allow ±1 cycle for asynchronous sampling.
- update never asserts for two consecutive cycles.
- Minimum spacing between updates is 3 cycles.
- Reset mid-operation (any state): asynchronous return to the reset values; an in-flight update pulse is truncated.
- Arithmetic: prog_sel is unsigned PROG_W bits with saturating increment/decrement and no wrap-around. Both counters are sized by $clog2 of their parameter, plus 1.

Decomposition:
- Shared package prog_ctrl_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT_ACK)
  - PROG_W constant
  - PROG_MAX = 2**PROG_W-1
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge pulse. Parameter DEBOUNCE_CYCLES; ports clock, reset, btn_raw, level, rise. Instantiated twice.
- The FSM and saturating arithmetic stay in prog_ctrl.

Test Plan:
1. Reset, then btn_up held high 20 cycles with prog_ack tied to the DCM model -> update pulses once ~8 cycles after press; prog_sel=1; busy high 2 cycles; error=0.
2. btn_up glitch high for 3 cycles -> no update; prog_sel stays 0.
3. Seven clean up presses, then an eighth -> prog_sel reaches 7 with 7 update pulses; the eighth press gives no update. Then a down press at 0 (after reset) -> no update.
4. btn_up and btn_down rising in the same cycle (equal debounce) -> no update; prog_sel unchanged.
5. prog_ack forced to 0 and up press -> update pulse; busy held 1+8 cycles; error=1 sticky; prog_sel=1. A further clean press still works and error stays 1.
6. Assert reset during WAIT_ACK -> all outputs return to 0 immediately (asynchronously); FSM=IDLE; the next press is handled normally.

Source files
------------

// File: rtl/prog_ctrl_pkg.sv
// Shared types and constants for the DCM programming control stage.
package prog_ctrl_pkg;

  localparam int PROG_W = 3;
  localparam logic [PROG_W-1:0] PROG_MAX = PROG_W'((2 ** PROG_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, debounce counter, registered rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/prog_ctrl.sv
// Button-driven 3-bit DCM speed selection: saturating up/down, one-cycle update,
// readback confirmation with timeout and sticky error.
module prog_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [PROG_W-1:0] prog_ack,
  output logic [PROG_W-1:0] prog_sel,
  output logic              update,
  output logic              busy,
  output logic              error
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [PROG_W-1:0] sel_q, sel_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic up_level, up_rise, down_level, down_rise;
  logic up_req, down_req;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_up),
    .level   (up_level),
    .rise    (up_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_down),
    .level   (down_level),
    .rise    (down_rise)
  );

  // Simultaneous up/down presses cancel each other.
  assign up_req   = up_rise & up_level & ~down_rise;
  assign down_req = down_rise & down_level & ~up_rise;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (up_req && (sel_q != PROG_MAX)) begin
          sel_d   = sel_q + 1'b1;
          state_d = ISSUE;
        end else if (down_req && (sel_q != '0)) begin
          sel_d   = sel_q - 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (prog_ack == sel_q) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign prog_sel = sel_q;
  assign update   = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign error    = err_q;

endmodule

// File: tb/tb_prog_ctrl.sv
// Directed bench for prog_ctrl with a register-on-update DCM readback model.
module tb_prog_ctrl;
  import prog_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              btn_up = 1'b0;
  logic              btn_down = 1'b0;
  logic [PROG_W-1:0] prog_ack;
  logic [PROG_W-1:0] prog_sel;
  logic              update, busy, error;

  logic              ack_zero = 1'b0;
  logic [PROG_W-1:0] dcm_q;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int busy_cnt = 0;
  int dbl_cnt = 0;
  int last_upd_cyc = 0;
  int press_cyc = 0;
  logic prev_upd = 1'b0;

  int upd_base, busy_base, lat;

  prog_ctrl #(.DEBOUNCE_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .prog_ack (prog_ack),
    .prog_sel (prog_sel),
    .update   (update),
    .busy     (busy),
    .error    (error)
  );

  always #5 clock = ~clock;

  // DCM model: latches prog_in on the update cycle, resets to code 0.
  always @(posedge clock or posedge reset) begin
    if (reset) dcm_q <= '0;
    else if (update) dcm_q <= prog_sel;
  end
  assign prog_ack = ack_zero ? '0 : dcm_q;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (update) begin
        upd_cnt = upd_cnt + 1;
        last_upd_cyc = cyc;
        if (prev_upd) dbl_cnt = dbl_cnt + 1;
      end
      if (busy) busy_cnt = busy_cnt + 1;
      prev_upd = update;
    end else begin
      prev_upd = 1'b0;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec = n_vec + 1;
    if (obs != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic press(input logic up, input logic dn, input int hold, input int settle);
    @(negedge clock);
    btn_up    = up;
    btn_down  = dn;
    press_cyc = cyc;
    repeat (hold) @(negedge clock);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (settle) @(negedge clock);
  endtask

  task automatic snap();
    upd_base  = upd_cnt;
    busy_base = busy_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_val("rst_prog_sel", int'(prog_sel), 0);
    check_val("rst_update", int'(update), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_error", int'(error), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: one clean up press
    snap();
    press(1'b1, 1'b0, 20, 12);
    lat = last_upd_cyc - press_cyc;
    check_val("t1_updates", upd_cnt - upd_base, 1);
    check_val("t1_latency_in_8pm1", int'(lat >= 7 && lat <= 9), 1);
    check_val("t1_prog_sel", int'(prog_sel), 1);
    check_val("t1_busy_cycles", busy_cnt - busy_base, 2);
    check_val("t1_error", int'(error), 0);

    // 2: 3-cycle glitch is filtered
    do_reset();
    snap();
    press(1'b1, 1'b0, 3, 15);
    check_val("t2_updates", upd_cnt - upd_base, 0);
    check_val("t2_prog_sel", int'(prog_sel), 0);

    // 3: saturate at 7, then down at 0
    do_reset();
    snap();
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 10, 12);
    check_val("t3_updates_7", upd_cnt - upd_base, 7);
    check_val("t3_prog_sel_7", int'(prog_sel), 7);
    snap();
    press(1'b1, 1'b0, 10, 12);
    check_val("t3_sat_hi_updates", upd_cnt - upd_base, 0);
    check_val("t3_sat_hi_sel", int'(prog_sel), 7);
    do_reset();
    snap();
    press(1'b0, 1'b1, 10, 12);
    check_val("t3_sat_lo_updates", upd_cnt - upd_base, 0);
    check_val("t3_sat_lo_sel", int'(prog_sel), 0);

    // 4: simultaneous up and down from code 1
    do_reset();
    press(1'b1, 1'b0, 10, 12);
    snap();
    press(1'b1, 1'b1, 10, 12);
    check_val("t4_updates", upd_cnt - upd_base, 0);
    check_val("t4_prog_sel", int'(prog_sel), 1);

    // 5: readback stuck at 0 -> timeout, sticky error
    do_reset();
    ack_zero = 1'b1;
    snap();
    press(1'b1, 1'b0, 20, 12);
    check_val("t5_updates", upd_cnt - upd_base, 1);
    check_val("t5_busy_cycles", busy_cnt - busy_base, 9);
    check_val("t5_error", int'(error), 1);
    check_val("t5_prog_sel", int'(prog_sel), 1);
    ack_zero = 1'b0;
    snap();
    press(1'b1, 1'b0, 20, 12);
    check_val("t5b_updates", upd_cnt - upd_base, 1);
    check_val("t5b_prog_sel", int'(prog_sel), 2);
    check_val("t5b_busy_cycles", busy_cnt - busy_base, 2);
    check_val("t5b_error_sticky", int'(error), 1);

    // 6: asynchronous reset while waiting for readback
    do_reset();
    ack_zero = 1'b1;
    @(negedge clock);
    btn_up = 1'b1;
    for (int i = 0; i < 30 && !update; i++) @(negedge clock);
    check_val("t6_update_seen", int'(update), 1);
    repeat (2) @(negedge clock);
    check_val("t6_busy_in_wait", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_val("t6_async_prog_sel", int'(prog_sel), 0);
    check_val("t6_async_busy", int'(busy), 0);
    check_val("t6_async_update", int'(update), 0);
    check_val("t6_async_error", int'(error), 0);
    btn_up   = 1'b0;
    ack_zero = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    snap();
    press(1'b1, 1'b0, 20, 12);
    check_val("t6_after_updates", upd_cnt - upd_base, 1);
    check_val("t6_after_prog_sel", int'(prog_sel), 1);
    check_val("t6_after_error", int'(error), 0);

    check_val("no_back_to_back_update", dbl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
